// File: rtl/spi_frame_receiver.sv
// SPI frame receiver (SPI mode 0, MSB first, receive only).
// The raw SCLK/COPI/nCS pins are brought into the clk domain, framed by nCS,
// and shifted on SCLK rising edges. A frame with exactly FRAME_BITS edges is
// published on frame_data with a one-clk frame_valid pulse. A short or overlong
// frame produces a one-clk frame_err pulse instead.
// Optional feature macro: SPI_GLITCH_FILTER_EN. When it is defined, SCLK goes
// through a 3-sample majority filter, and COPI and nCS are delayed to match.
module spi_frame_receiver #(
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk_in,
    input  logic                  copi_in,
    input  logic                  ncs_in,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    logic [1:0] sclk_sync;
    logic [1:0] copi_sync;
    logic [1:0] ncs_sync;

    logic sclk_lvl;
    logic copi_lvl;
    logic ncs_lvl;
    logic sclk_prev;
    logic ncs_prev;
    logic sclk_rise;
    logic ncs_rise;
    logic ncs_fall;

    state_t                state;
    logic [CW-1:0]         count;
    logic [FRAME_BITS-1:0] shift;

    // Two-flop synchronizers for all three pins. nCS clears to 0 as well, so a
    // frame already in progress when reset is released never shows a falling edge.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_in};
            copi_sync <= {copi_sync[0], copi_in};
            ncs_sync  <= {ncs_sync[0], ncs_in};
        end
    end

`ifdef SPI_GLITCH_FILTER_EN
    logic [2:0] sclk_hist;
    logic [1:0] copi_dly;
    logic [1:0] ncs_dly;

    // Three-sample SCLK history for the majority vote. COPI and nCS get two
    // matching delay stages so all three lines stay aligned behind the filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_hist <= '0;
            copi_dly  <= '0;
            ncs_dly   <= '0;
        end else begin
            sclk_hist <= {sclk_hist[1:0], sclk_sync[1]};
            copi_dly  <= {copi_dly[0], copi_sync[1]};
            ncs_dly   <= {ncs_dly[0], ncs_sync[1]};
        end
    end

    // A 1-clk pulse occupies only one of the three samples, so the vote drops it.
    assign sclk_lvl = (sclk_hist[0] & sclk_hist[1]) |
                      (sclk_hist[1] & sclk_hist[2]) |
                      (sclk_hist[0] & sclk_hist[2]);
    assign copi_lvl = copi_dly[1];
    assign ncs_lvl  = ncs_dly[1];
`else
    // COPI is taken from the same synchronizer stage as SCLK, so both see equal delay.
    assign sclk_lvl = sclk_sync[1];
    assign copi_lvl = copi_sync[1];
    assign ncs_lvl  = ncs_sync[1];
`endif

    // Edge-detect flops that hold the previous SCLK and nCS levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b0;
        end else begin
            sclk_prev <= sclk_lvl;
            ncs_prev  <= ncs_lvl;
        end
    end

    assign sclk_rise = sclk_lvl & ~sclk_prev;
    assign ncs_rise  = ncs_lvl & ~ncs_prev;
    assign ncs_fall  = ~ncs_lvl & ncs_prev;

    // Frame FSM. An nCS rising edge is tested before SCLK, so it wins when both
    // edges arrive in the same cycle. The output pulses default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            shift       <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state <= ACTIVE;
                        count <= '0;
                        shift <= '0;
                    end
                end
                ACTIVE: begin
                    if (ncs_rise) begin
                        state <= IDLE;
                        if (count == CW'(FRAME_BITS)) begin
                            frame_data  <= shift;
                            frame_valid <= 1'b1;
                        end else if (count != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        if (count == CW'(FRAME_BITS)) begin
                            state <= OVERRUN;
                        end else begin
                            shift <= {shift[FRAME_BITS-2:0], copi_lvl};
                            count <= count + 1'b1;
                        end
                    end
                end
                OVERRUN: begin
                    if (ncs_rise) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/spi_frame_receiver.md
SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

Interface
REQ-001 SHALL provide parameter FRAME_BITS, default 16: bits per valid frame, legal range 2..32.
REQ-002 SHALL provide port clk, input, 1: single system clock; all flops on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL provide port sclk_in, input, 1: raw SPI clock pin, asynchronous to clk.
REQ-005 SHALL provide port copi_in, input, 1: raw SPI data pin, asynchronous to clk.
REQ-006 SHALL provide port ncs_in, input, 1: raw SPI chip select pin, active-low, asynchronous to clk.
REQ-007 SHALL provide port frame_data, output, FRAME_BITS: most recent valid frame, MSB first on the wire.
REQ-008 SHALL provide port frame_valid, output, 1: one-clk pulse when frame_data updates.
REQ-009 SHALL provide port frame_err, output, 1: one-clk pulse on a short or overlong frame.
REQ-010 SHALL provide port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-011 SHALL pass sclk_in, copi_in and ncs_in each through a 2-flop synchronizer, plus a third flop for edge detection.
REQ-012 SHALL sample COPI from the synchronized stage aligned with SCLK, so both lines see equal delay.
REQ-013 SHALL implement states IDLE, ACTIVE and OVERRUN.
REQ-014 IDLE -> ACTIVE on synchronized nCS falling edge, clearing bit counter and shift register.
REQ-015 ACTIVE: each synchronized SCLK rising edge SHALL shift {shift[FRAME_BITS-2:0], copi} and increment the counter; falling edges are ignored.
REQ-016 ACTIVE -> OVERRUN on SCLK rising edge number FRAME_BITS+1; OVERRUN ignores further SCLK edges.
REQ-017 On synchronized nCS rising edge in ACTIVE with count == FRAME_BITS: load frame_data from the shift register, pulse frame_valid, go to IDLE.
REQ-018 On nCS rising edge in ACTIVE with count 1..FRAME_BITS-1, or in OVERRUN: pulse frame_err, leave frame_data unchanged, go to IDLE.
REQ-019 On nCS rising edge in ACTIVE with count 0: no pulse, go to IDLE.
REQ-020 SCLK rising and nCS rising detected in the same clk cycle: nCS SHALL win and the SCLK edge SHALL be discarded.
REQ-021 nCS rising edge in IDLE SHALL be ignored.
REQ-022 frame_valid and frame_err SHALL be registered, mutually exclusive, and exactly one clk wide.
REQ-023 Latency: frame_valid/frame_err SHALL assert on the 3rd clk rising edge after the first edge that samples ncs_in high (filter off).
REQ-024 Correct operation SHALL require an SCLK high time and low time each >= 2 clk periods (>= 3 with filter).
REQ-025 frame_data SHALL hold its value indefinitely between valid frames.

Reset
REQ-026 rst_n low SHALL clear asynchronously: state=IDLE, counter=0, shift register=0, frame_data=0, frame_valid=0, frame_err=0, busy=0.
REQ-027 On reset, all synchronizer/edge flops SHALL clear to 0, including nCS.
REQ-028 A frame in progress at reset release SHALL be ignored until nCS rises and falls again; no pulse SHALL result from it.

Configuration
REQ-029 Macro SPI_GLITCH_FILTER_EN defined: SCLK SHALL pass through a 3-sample majority filter after synchronization.
REQ-030 With the filter, SCLK and COPI SHALL be delayed equally, and nCS-to-pulse latency SHALL grow by 2 clk (5 clk total).
REQ-031 Macro undefined: no filter, latency per REQ-023.

Verification
REQ-032 16 SCLK edges, COPI=0xA55A, nCS high -> frame_valid one-clk pulse, frame_data=0xA55A, frame_err=0.
REQ-033 15 SCLK edges then nCS high -> frame_err pulse, frame_valid=0, frame_data retains previous 0xA55A.
REQ-034 17 SCLK edges with COPI=0xFFFF then nCS high -> state OVERRUN before nCS rises, frame_err pulse, frame_data unchanged.
REQ-035 rst_n low after 8 bits with nCS held low, 8 more bits, nCS high -> no frame_valid and no frame_err; frame_data=0.
REQ-036 nCS rising and 16th SCLK rising reach the synchronizer outputs in the same cycle -> count stays 15, frame_err pulse.
REQ-037 SPI_GLITCH_FILTER_EN defined, 1-clk SCLK glitches injected during a 0x1234 frame -> frame_data=0x1234, valid pulse 5 clk after nCS high.
